// File: rtl/sensor_pkg.sv
// Shared definitions for the IMU sensor frame receiver.
//  - frame_state_e : frame decoder states (HUNT, TYPE, DATA, SUM)
//  - rx_state_e    : UART byte receiver states
//  - HEADER / TYPE_* : frame header and frame type codes
//  - FRAME_DATA_LEN  : number of payload bytes between type and checksum
//  - sum8 / get_word : checksum accumulation and payload word extraction
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_SUM  = 2'd3
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] HEADER     = 8'h55;
    localparam logic [7:0] TYPE_ACC   = 8'h51;
    localparam logic [7:0] TYPE_GYRO  = 8'h52;
    localparam logic [7:0] TYPE_ANGLE = 8'h53;
    localparam logic [7:0] TYPE_MAG   = 8'h54;

    localparam int unsigned FRAME_DATA_LEN = 8;

    // Frame checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        sum8 = a + b;
    endfunction

    // Payload bytes are packed little-endian, so word n is bits [16n+15:16n].
    function automatic logic [15:0] get_word(input logic [63:0] d, input logic [1:0] n);
        case (n)
            2'd0:    get_word = d[15:0];
            2'd1:    get_word = d[31:16];
            2'd2:    get_word = d[47:32];
            2'd3:    get_word = d[63:48];
            default: get_word = d[15:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver, LSB first.
// Ports:
//  clk_uart : receiver clock (CLKS_PER_BIT cycles per bit)
//  rst      : asynchronous active-low reset
//  rxd      : raw serial input, idle high
//  data     : received byte, valid while 'valid' is high
//  valid    : one-cycle strobe for each byte with a good stop bit
module uart_rx
    import sensor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk_uart,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        r_state;
    rx_state_e        w_next;
    logic [1:0]       r_sync;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;

    logic             w_rx;
    logic             w_tick_half;
    logic             w_tick_bit;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_byte_done;

    assign w_rx        = r_sync[1];
    assign w_tick_half = (r_cnt == HALF_LAST);
    assign w_tick_bit  = (r_cnt == BIT_LAST);
    assign data        = r_data;
    assign valid       = r_valid;

    // Receiver state register.
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: start-bit recheck at half bit, then data/stop at full bit periods.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (r_prev && !w_rx) begin
                    w_next = RX_START;
                end else begin
                    w_next = RX_IDLE;
                end
            end
            RX_START: begin
                if (w_tick_half) begin
                    // A high line at mid start bit was only a glitch.
                    w_next = w_rx ? RX_IDLE : RX_DATA;
                end else begin
                    w_next = RX_START;
                end
            end
            RX_DATA: begin
                if (w_tick_bit && (r_bit_idx == 3'd7)) begin
                    w_next = RX_STOP;
                end else begin
                    w_next = RX_DATA;
                end
            end
            RX_STOP: begin
                // Rearm right after the mid-stop sample so back-to-back bytes work.
                if (w_tick_bit) begin
                    w_next = RX_IDLE;
                end else begin
                    w_next = RX_STOP;
                end
            end
            default: w_next = RX_IDLE;
        endcase
    end

    // Control strobes decoded from the current state and bit timer.
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_done = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
            end
            RX_START: begin
                if (w_tick_half) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_clr = 1'b0;
                end
            end
            RX_DATA: begin
                if (w_tick_bit) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                end else begin
                    w_cnt_clr  = 1'b0;
                    w_shift_en = 1'b0;
                end
            end
            RX_STOP: begin
                if (w_tick_bit) begin
                    w_cnt_clr   = 1'b1;
                    w_byte_done = w_rx;
                end else begin
                    w_cnt_clr   = 1'b0;
                    w_byte_done = 1'b0;
                end
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    // Synchronizer, bit timer, shift register and byte output.
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_prev    <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rxd};
            r_prev  <= w_rx;
            r_valid <= w_byte_done;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state != RX_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
            // LSB arrives first, so shift in from the top.
            if (w_shift_en) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end else begin
                r_shift <= r_shift;
            end
            if (w_byte_done) begin
                r_data <= r_shift;
            end else begin
                r_data <= r_data;
            end
        end
    end

endmodule

// File: rtl/sensor_receiver.sv
// IMU sensor frame receiver: decodes 11-byte frames (0x55, type, 8 data
// bytes, checksum) from the wireless module and publishes acceleration and
// yaw words.
// Ports:
//  clk_uart     : UART clock, single clock domain
//  rst          : asynchronous active-low reset
//  wireless_tx  : serial data from the wireless module, idle high
//  wireless_rx  : serial data to the wireless module, held idle high
//  wireless_set : module SET pin, held high (normal mode)
//  acceleration : signed, word ACC_INDEX of the last good ACC_TYPE frame
//  direction    : signed, word DIR_INDEX of the last good DIR_TYPE frame
module sensor_receiver
    import sensor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter logic [7:0]  ACC_TYPE     = 8'h51,
    parameter logic [7:0]  DIR_TYPE     = 8'h53,
    parameter int unsigned ACC_INDEX    = 0,
    parameter int unsigned DIR_INDEX    = 2
) (
    input  logic               clk_uart,
    input  logic               rst,
    input  logic               wireless_tx,
    output logic               wireless_rx,
    output logic               wireless_set,
    output logic signed [15:0] acceleration,
    output logic signed [15:0] direction
);

    frame_state_e       r_state;
    frame_state_e       w_next;
    logic [7:0]         r_type;
    logic [7:0]         r_sum;
    logic [2:0]         r_idx;
    logic [63:0]        r_frame_data;
    logic signed [15:0] r_acc;
    logic signed [15:0] r_dir;
    logic               r_wireless_rx;
    logic               r_wireless_set;

    logic [7:0]         w_byte;
    logic               w_byte_valid;
    logic               w_store_type;
    logic               w_store_data;
    logic               w_load_acc;
    logic               w_load_dir;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_uart (clk_uart),
        .rst      (rst),
        .rxd      (wireless_tx),
        .data     (w_byte),
        .valid    (w_byte_valid)
    );

    assign acceleration = r_acc;
    assign direction    = r_dir;
    assign wireless_rx  = r_wireless_rx;
    assign wireless_set = r_wireless_set;

    // Frame state register.
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame next-state; moves only when a byte arrives, so an idle bus just waits.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_byte_valid && (w_byte == HEADER)) begin
                    w_next = ST_TYPE;
                end else begin
                    w_next = ST_HUNT;
                end
            end
            ST_TYPE: begin
                if (w_byte_valid) begin
                    w_next = ST_DATA;
                end else begin
                    w_next = ST_TYPE;
                end
            end
            ST_DATA: begin
                // A 0x55 here is payload, not a resync.
                if (w_byte_valid && (r_idx == 3'(FRAME_DATA_LEN - 1))) begin
                    w_next = ST_SUM;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_SUM: begin
                // Good or bad checksum, the frame is finished; no rescan of its bytes.
                if (w_byte_valid) begin
                    w_next = ST_HUNT;
                end else begin
                    w_next = ST_SUM;
                end
            end
            default: w_next = ST_HUNT;
        endcase
    end

    // Frame datapath enables.
    always_comb begin
        w_store_type = 1'b0;
        w_store_data = 1'b0;
        w_load_acc   = 1'b0;
        w_load_dir   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_store_type = 1'b0;
            end
            ST_TYPE: begin
                w_store_type = w_byte_valid;
            end
            ST_DATA: begin
                w_store_data = w_byte_valid;
            end
            ST_SUM: begin
                if (w_byte_valid && (w_byte == r_sum)) begin
                    w_load_acc = (r_type == ACC_TYPE);
                    w_load_dir = (r_type == DIR_TYPE);
                end else begin
                    w_load_acc = 1'b0;
                    w_load_dir = 1'b0;
                end
            end
            default: w_store_type = 1'b0;
        endcase
    end

    // Frame type, running checksum and payload buffer.
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            r_type       <= 8'h00;
            r_sum        <= 8'h00;
            r_idx        <= 3'd0;
            r_frame_data <= 64'h0;
        end else if (w_store_type) begin
            r_type <= w_byte;
            r_sum  <= sum8(HEADER, w_byte);
            r_idx  <= 3'd0;
        end else if (w_store_data) begin
            r_frame_data[{r_idx, 3'b000} +: 8] <= w_byte;
            r_sum <= sum8(r_sum, w_byte);
            r_idx <= r_idx + 3'd1;
        end else begin
            r_type       <= r_type;
            r_sum        <= r_sum;
            r_idx        <= r_idx;
            r_frame_data <= r_frame_data;
        end
    end

    // Published outputs; the transmit line and SET pin are held high.
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            r_acc          <= 16'sd0;
            r_dir          <= 16'sd0;
            r_wireless_rx  <= 1'b1;
            r_wireless_set <= 1'b1;
        end else begin
            r_wireless_rx  <= 1'b1;
            r_wireless_set <= 1'b1;
            if (w_load_acc) begin
                r_acc <= get_word(r_frame_data, 2'(ACC_INDEX));
            end else begin
                r_acc <= r_acc;
            end
            if (w_load_dir) begin
                r_dir <= get_word(r_frame_data, 2'(DIR_INDEX));
            end else begin
                r_dir <= r_dir;
            end
        end
    end

endmodule

// File: tb/tb_sensor_receiver.sv
// Scoreboard bench for sensor_receiver: serial frames are driven on
// wireless_tx, a list-based frame model queues the expected output updates,
// and a monitor compares each observed output change against the queue.
module tb_sensor_receiver;

    localparam int BIT_CLKS = 8;

    logic        clk_uart = 1'b0;
    logic        rst;
    logic        wireless_tx;
    logic        wireless_rx;
    logic        wireless_set;
    logic [15:0] acceleration;
    logic [15:0] direction;

    typedef struct {
        logic        is_dir;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  m_frame[$];
    logic [15:0] m_acc;
    logic [15:0] m_dir;
    logic [15:0] last_acc;
    logic [15:0] last_dir;
    bit          mon_en;
    int          n_cmp;
    int          n_fail;

    always #5 clk_uart = ~clk_uart;

    sensor_receiver dut (
        .clk_uart     (clk_uart),
        .rst          (rst),
        .wireless_tx  (wireless_tx),
        .wireless_rx  (wireless_rx),
        .wireless_set (wireless_set),
        .acceleration (acceleration),
        .direction    (direction)
    );

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect bytes from a 0x55 until 11 are held, then judge the frame.
    task automatic model_byte(input logic [7:0] b);
        int          s;
        logic [15:0] w;
        exp_t        e;
        if (m_frame.size() == 0 && b != 8'h55) return;
        m_frame.push_back(b);
        if (m_frame.size() == 11) begin
            s = 0;
            for (int i = 0; i < 10; i++) s = s + int'(m_frame[i]);
            if ((s % 256) == int'(m_frame[10])) begin
                if (m_frame[1] == 8'h51) begin
                    w = {m_frame[3], m_frame[2]};
                    if (w != m_acc) begin
                        e.is_dir = 1'b0; e.val = w; sb_q.push_back(e);
                    end
                    m_acc = w;
                end
                if (m_frame[1] == 8'h53) begin
                    w = {m_frame[7], m_frame[6]};
                    if (w != m_dir) begin
                        e.is_dir = 1'b1; e.val = w; sb_q.push_back(e);
                    end
                    m_dir = w;
                end
            end
            m_frame.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) model_byte(b);
        @(negedge clk_uart) wireless_tx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk_uart);
        for (int i = 0; i < 8; i++) begin
            wireless_tx = b[i];
            repeat (BIT_CLKS) @(negedge clk_uart);
        end
        wireless_tx = stop_ok;
        repeat (BIT_CLKS) @(negedge clk_uart);
        wireless_tx = 1'b1;
        if (!stop_ok) repeat (BIT_CLKS) @(negedge clk_uart);
        repeat ($urandom_range(0, 3)) @(negedge clk_uart);
    endtask

    task automatic send_frame(input logic [7:0] typ, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3, input logic [7:0] sum_err);
        logic [7:0] b[11];
        logic [7:0] s;
        b[0] = 8'h55; b[1] = typ;
        b[2] = w0[7:0]; b[3] = w0[15:8]; b[4] = w1[7:0]; b[5] = w1[15:8];
        b[6] = w2[7:0]; b[7] = w2[15:8]; b[8] = w3[7:0]; b[9] = w3[15:8];
        s = 8'h00;
        for (int i = 0; i < 10; i++) s = s + b[i];
        b[10] = s + sum_err;
        for (int i = 0; i < 11; i++) send_byte(b[i], 1'b1);
    endtask

    // Let the last byte settle, then confirm every queued update appeared.
    task automatic settle(input string name);
        repeat (6) @(negedge clk_uart);
        #1;
        check({name, "_pending"}, 17'(sb_q.size()), 17'd0);
        sb_q.delete();
        check({name, "_acc"}, {1'b0, acceleration}, {1'b0, m_acc});
        check({name, "_dir"}, {1'b0, direction}, {1'b0, m_dir});
    endtask

    // Monitor: every change of a published output must match the scoreboard head.
    always @(negedge clk_uart) begin
        exp_t e;
        if (!mon_en) begin
            last_acc = 16'h0000;
            last_dir = 16'h0000;
        end else begin
            if (acceleration !== last_acc) begin
                if (sb_q.size() == 0) begin
                    check("acc_unexpected", {1'b0, acceleration}, {1'b0, last_acc});
                end else begin
                    e = sb_q.pop_front();
                    check("acc_update", {1'b0, acceleration}, {e.is_dir, e.val});
                end
                last_acc = acceleration;
            end
            if (direction !== last_dir) begin
                if (sb_q.size() == 0) begin
                    check("dir_unexpected", {1'b1, direction}, {1'b1, last_dir});
                end else begin
                    e = sb_q.pop_front();
                    check("dir_update", {1'b1, direction}, {e.is_dir, e.val});
                end
                last_dir = direction;
            end
        end
    end

    initial begin
        logic [7:0] types[5];
        logic [7:0] noise;
        n_cmp = 0; n_fail = 0; mon_en = 1'b0;
        m_acc = 16'h0000; m_dir = 16'h0000;
        wireless_tx = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk_uart);
        #1;
        check("rst_acc", {1'b0, acceleration}, 17'h00000);
        check("rst_dir", {1'b0, direction}, 17'h00000);
        check("rst_rx_set", {15'h0, wireless_rx, wireless_set}, 17'h00003);
        @(negedge clk_uart) rst = 1'b1;
        #1 mon_en = 1'b1;

        send_frame(8'h51, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 8'h00);
        settle("acc_frame");
        check("acc_const", {1'b0, acceleration}, 17'h00123);
        check("dir_still0", {1'b0, direction}, 17'h00000);

        send_frame(8'h52, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 8'h00);
        settle("gyro_frame");

        send_byte(8'h76, 1'b1);
        send_frame(8'h53, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 8'h00);
        settle("noise_dir");
        check("dir_const", {1'b0, direction}, 17'h089AB);

        send_frame(8'h53, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 8'h00);
        settle("dir2");
        check("dir2_const", {1'b0, direction}, 17'h07654);

        send_byte(8'h13, 1'b1);
        send_frame(8'h52, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 8'h00);
        send_frame(8'h51, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 8'h00);
        settle("acc_neg");
        check("acc_neg_const", {1'b0, acceleration}, 17'h0FEDC);

        send_frame(8'h51, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'h01);
        settle("bad_sum");
        check("bad_sum_hold", {1'b0, acceleration}, 17'h0FEDC);

        send_frame(8'h51, 16'h0A0B, 16'h5555, 16'h0C0D, 16'h0E0F, 8'h00);
        settle("after_bad");
        check("after_bad_const", {1'b0, acceleration}, 17'h00A0B);

        // Short start glitch, then a byte with a bad stop bit; neither may count.
        @(negedge clk_uart) wireless_tx = 1'b0;
        repeat (2) @(negedge clk_uart);
        wireless_tx = 1'b1;
        repeat (20) @(negedge clk_uart);
        send_byte(8'h55, 1'b0);
        send_frame(8'h53, 16'h1357, 16'h2468, 16'h8001, 16'h0000, 8'h00);
        settle("glitch_framing");

        // Reset in the middle of a frame.
        send_byte(8'h55, 1'b1);
        send_byte(8'h51, 1'b1);
        send_byte(8'h99, 1'b1);
        @(negedge clk_uart) wireless_tx = 1'b0;
        repeat (20) @(negedge clk_uart);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_acc", {1'b0, acceleration}, 17'h00000);
        check("midrst_dir", {1'b0, direction}, 17'h00000);
        check("midrst_rx_set", {15'h0, wireless_rx, wireless_set}, 17'h00003);
        m_frame.delete(); sb_q.delete();
        m_acc = 16'h0000; m_dir = 16'h0000;
        wireless_tx = 1'b1;
        repeat (3) @(negedge clk_uart);
        rst = 1'b1;
        #1 mon_en = 1'b1;
        send_frame(8'h51, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 8'h00);
        settle("post_rst");
        check("post_rst_const", {1'b0, acceleration}, 17'h00123);

        // Randomized frames, types, noise and corrupted checksums.
        types[0] = 8'h51; types[1] = 8'h52; types[2] = 8'h53; types[3] = 8'h54;
        for (int n = 0; n < 25; n++) begin
            types[4] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                noise = 8'($urandom_range(0, 255));
                if (noise == 8'h55) noise = 8'h56;
                send_byte(noise, 1'b1);
            end
            send_frame(types[$urandom_range(0, 4)],
                       16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            settle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
